// File: rtl/sdhci_dat_xfer_ctrl.sv
// SD host DAT-line block transfer sequencer.
// Schedules one block at a time between the data buffer and the DAT PHY,
// maintains the remaining-block counter, writes the block count back to the
// register logic and requests Auto CMD12 at the end of multi-block transfers.
module sdhci_dat_xfer_ctrl #(
  parameter int MaxBlockSize = 2048
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic        dir_read_i,
  input  logic        multi_block_i,
  input  logic        block_count_en_i,
  input  logic        auto_cmd12_en_i,
  input  logic [15:0] block_count_i,
  input  logic [11:0] block_size_i,
  input  logic        abort_i,
  output logic        blk_start_o,
  output logic [11:0] blk_len_o,
  input  logic        blk_done_i,
  input  logic        blk_err_i,
  input  logic        buf_block_written_i,
  input  logic        buf_block_drained_i,
  output logic        read_transfer_active_o,
  output logic        write_transfer_active_o,
  output logic        buffer_read_enable_o,
  output logic        buffer_write_enable_o,
  output logic        block_count_de_o,
  output logic [15:0] block_count_d_o,
  output logic        auto_cmd12_req_o,
  input  logic        auto_cmd12_done_i,
  output logic        data_error_o
);

  typedef enum logic [2:0] {
    IDLE,
    WR_WAIT_BUF,
    WR_BUSY,
    RD_BUSY,
    RD_WAIT_DRAIN,
    CMD12,
    FINISH
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] remain_q, remain_d;
  logic [11:0] size_q, size_d;
  logic        multi_q, multi_d;
  logic        count_en_q, count_en_d;
  logic        acmd12_q, acmd12_d;
  logic        cmd12_pend_q, cmd12_pend_d;

  logic        blk_start_q, blk_start_d;
  logic        rd_active_q, rd_active_d;
  logic        wr_active_q, wr_active_d;
  logic        buf_rd_en_q, buf_rd_en_d;
  logic        buf_wr_en_q, buf_wr_en_d;
  logic        bc_de_q, bc_de_d;
  logic [15:0] bc_val_q, bc_val_d;
  logic        cmd12_req_q, cmd12_req_d;
  logic        data_err_q, data_err_d;

  logic        counted;
  logic        infinite;
  logic        last_blk;
  logic        drained_last;
  logic        use_cmd12;
  logic        zero_count;
  logic [11:0] size_clamped;

  // Counted mode writes the count back; infinite mode never ends on its own.
  assign counted      = multi_q & count_en_q;
  assign infinite     = multi_q & ~count_en_q;
  // The block on the line is the last one when only it remains.
  assign last_blk     = ~infinite & (remain_q == 16'd1);
  // After the last block's decrement the counter sits at zero while draining.
  assign drained_last = ~infinite & (remain_q == 16'd0);
  assign use_cmd12    = multi_q & acmd12_q;
  assign zero_count   = multi_block_i & block_count_en_i & (block_count_i == 16'd0);
  assign size_clamped = (int'(block_size_i) > MaxBlockSize) ? 12'(MaxBlockSize) : block_size_i;

  // Next-state and next-output logic for the block sequencer.
  always_comb begin
    // NOTE: every _d signal gets its hold value first; a path that leaves one unassigned would infer a latch.
    state_d      = state_q;
    remain_d     = remain_q;
    size_d       = size_q;
    multi_d      = multi_q;
    count_en_d   = count_en_q;
    acmd12_d     = acmd12_q;
    cmd12_pend_d = cmd12_pend_q;
    rd_active_d  = rd_active_q;
    wr_active_d  = wr_active_q;
    buf_rd_en_d  = buf_rd_en_q;
    buf_wr_en_d  = buf_wr_en_q;
    bc_val_d     = bc_val_q;
    blk_start_d  = 1'b0;
    bc_de_d      = 1'b0;
    cmd12_req_d  = 1'b0;
    data_err_d   = 1'b0;

    if (state_q != IDLE && abort_i) begin
      // Abort wins over any PHY or buffer event in the same cycle.
      state_d      = IDLE;
      rd_active_d  = 1'b0;
      wr_active_d  = 1'b0;
      buf_rd_en_d  = 1'b0;
      buf_wr_en_d  = 1'b0;
      cmd12_pend_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_i && !zero_count) begin
            size_d     = size_clamped;
            multi_d    = multi_block_i;
            count_en_d = block_count_en_i;
            acmd12_d   = auto_cmd12_en_i;
            remain_d   = multi_block_i ? block_count_i : 16'd1;
            if (dir_read_i) begin
              rd_active_d = 1'b1;
              blk_start_d = 1'b1;
              state_d     = RD_BUSY;
            end else begin
              wr_active_d = 1'b1;
              buf_wr_en_d = 1'b1;
              state_d     = WR_WAIT_BUF;
            end
          end
        end

        WR_WAIT_BUF: begin
          if (buf_block_written_i) begin
            buf_wr_en_d = 1'b0;
            blk_start_d = 1'b1;
            state_d     = WR_BUSY;
          end
        end

        WR_BUSY: begin
          if (blk_err_i) begin
            data_err_d  = 1'b1;
            cmd12_req_d = use_cmd12;
            state_d     = use_cmd12 ? CMD12 : FINISH;
          end else if (blk_done_i) begin
            if (!infinite) remain_d = remain_q - 16'd1;
            bc_de_d = counted;
            if (counted) bc_val_d = remain_q - 16'd1;
            if (last_blk) begin
              cmd12_req_d = use_cmd12;
              state_d     = use_cmd12 ? CMD12 : FINISH;
            end else begin
              buf_wr_en_d = 1'b1;
              state_d     = WR_WAIT_BUF;
            end
          end
        end

        RD_BUSY: begin
          if (blk_err_i) begin
            data_err_d  = 1'b1;
            cmd12_req_d = use_cmd12;
            state_d     = use_cmd12 ? CMD12 : FINISH;
          end else if (blk_done_i) begin
            if (!infinite) remain_d = remain_q - 16'd1;
            bc_de_d = counted;
            if (counted) bc_val_d = remain_q - 16'd1;
            buf_rd_en_d = 1'b1;
            // CMD12 for a read goes out while the host is still draining.
            if (last_blk && use_cmd12) begin
              cmd12_req_d  = 1'b1;
              cmd12_pend_d = 1'b1;
            end
            state_d = RD_WAIT_DRAIN;
          end
        end

        RD_WAIT_DRAIN: begin
          if (auto_cmd12_done_i) cmd12_pend_d = 1'b0;
          if (buf_block_drained_i) begin
            buf_rd_en_d = 1'b0;
            if (!drained_last) begin
              blk_start_d = 1'b1;
              state_d     = RD_BUSY;
            end else if (cmd12_pend_q && !auto_cmd12_done_i) begin
              state_d = CMD12;
            end else begin
              state_d = FINISH;
            end
          end
        end

        CMD12: begin
          if (auto_cmd12_done_i) begin
            cmd12_pend_d = 1'b0;
            state_d      = FINISH;
          end
        end

        FINISH: begin
          rd_active_d = 1'b0;
          wr_active_d = 1'b0;
          state_d     = IDLE;
        end

        default: state_d = IDLE;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Transfer context, counter and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      remain_q     <= 16'd0;
      size_q       <= 12'd0;
      multi_q      <= 1'b0;
      count_en_q   <= 1'b0;
      acmd12_q     <= 1'b0;
      cmd12_pend_q <= 1'b0;
      blk_start_q  <= 1'b0;
      rd_active_q  <= 1'b0;
      wr_active_q  <= 1'b0;
      buf_rd_en_q  <= 1'b0;
      buf_wr_en_q  <= 1'b0;
      bc_de_q      <= 1'b0;
      bc_val_q     <= 16'd0;
      cmd12_req_q  <= 1'b0;
      data_err_q   <= 1'b0;
    end else begin
      remain_q     <= remain_d;
      size_q       <= size_d;
      multi_q      <= multi_d;
      count_en_q   <= count_en_d;
      acmd12_q     <= acmd12_d;
      cmd12_pend_q <= cmd12_pend_d;
      blk_start_q  <= blk_start_d;
      rd_active_q  <= rd_active_d;
      wr_active_q  <= wr_active_d;
      buf_rd_en_q  <= buf_rd_en_d;
      buf_wr_en_q  <= buf_wr_en_d;
      bc_de_q      <= bc_de_d;
      bc_val_q     <= bc_val_d;
      cmd12_req_q  <= cmd12_req_d;
      data_err_q   <= data_err_d;
    end
  end

  assign blk_start_o             = blk_start_q;
  assign blk_len_o               = size_q;
  assign read_transfer_active_o  = rd_active_q;
  assign write_transfer_active_o = wr_active_q;
  assign buffer_read_enable_o    = buf_rd_en_q;
  assign buffer_write_enable_o   = buf_wr_en_q;
  assign block_count_de_o        = bc_de_q;
  assign block_count_d_o         = bc_val_q;
  assign auto_cmd12_req_o        = cmd12_req_q;
  assign data_error_o            = data_err_q;

endmodule

// File: tb/tb_sdhci_dat_xfer_ctrl.sv
// Testbench for sdhci_dat_xfer_ctrl: a driver plays PHY and host buffer,
// a transfer-level model queues the expected pulses, and a negedge monitor
// pops and compares them whenever the DUT emits a pulse.
module tb_sdhci_dat_xfer_ctrl;

  localparam int MaxBlk = 2048;
  localparam int NoErr  = 1000;

  localparam int W_BWE = 0, W_BRE = 1, W_START = 2, W_REQ = 3, W_IDLE = 4;
  localparam int P_START = 0, P_WR = 1, P_DRAIN = 2, P_DONE = 3, P_ERR = 4,
                 P_ERRDONE = 5, P_ABORT = 6, P_CMD12 = 7, P_DRAIN_CMD12 = 8;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_i = 1'b0;
  logic        dir_read_i = 1'b0;
  logic        multi_block_i = 1'b0;
  logic        block_count_en_i = 1'b0;
  logic        auto_cmd12_en_i = 1'b0;
  logic [15:0] block_count_i = 16'd0;
  logic [11:0] block_size_i = 12'd0;
  logic        abort_i = 1'b0;
  logic        blk_start_o;
  logic [11:0] blk_len_o;
  logic        blk_done_i = 1'b0;
  logic        blk_err_i = 1'b0;
  logic        buf_block_written_i = 1'b0;
  logic        buf_block_drained_i = 1'b0;
  logic        read_transfer_active_o;
  logic        write_transfer_active_o;
  logic        buffer_read_enable_o;
  logic        buffer_write_enable_o;
  logic        block_count_de_o;
  logic [15:0] block_count_d_o;
  logic        auto_cmd12_req_o;
  logic        auto_cmd12_done_i = 1'b0;
  logic        data_error_o;

  always #5 clk_i = ~clk_i;

  sdhci_dat_xfer_ctrl #(.MaxBlockSize(MaxBlk)) dut (
    .clk_i                   (clk_i),
    .rst_ni                  (rst_ni),
    .start_i                 (start_i),
    .dir_read_i              (dir_read_i),
    .multi_block_i           (multi_block_i),
    .block_count_en_i        (block_count_en_i),
    .auto_cmd12_en_i         (auto_cmd12_en_i),
    .block_count_i           (block_count_i),
    .block_size_i            (block_size_i),
    .abort_i                 (abort_i),
    .blk_start_o             (blk_start_o),
    .blk_len_o               (blk_len_o),
    .blk_done_i              (blk_done_i),
    .blk_err_i               (blk_err_i),
    .buf_block_written_i     (buf_block_written_i),
    .buf_block_drained_i     (buf_block_drained_i),
    .read_transfer_active_o  (read_transfer_active_o),
    .write_transfer_active_o (write_transfer_active_o),
    .buffer_read_enable_o    (buffer_read_enable_o),
    .buffer_write_enable_o   (buffer_write_enable_o),
    .block_count_de_o        (block_count_de_o),
    .block_count_d_o         (block_count_d_o),
    .auto_cmd12_req_o        (auto_cmd12_req_o),
    .auto_cmd12_done_i       (auto_cmd12_done_i),
    .data_error_o            (data_error_o)
  );

  int errors = 0;
  int checks = 0;
  int exp_len_q[$];
  int exp_d_q[$];
  int exp_cmd12_q[$];
  int exp_err_q[$];
  int last_len = 0;
  int last_d = 0;
  bit force_errdone = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every DUT pulse must match the next queued expectation.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (blk_start_o) begin
        if (exp_len_q.size() == 0) check("blk_start_unexpected", int'(blk_start_o), 0);
        else check("blk_len", int'(blk_len_o), exp_len_q.pop_front());
      end
      if (block_count_de_o) begin
        if (exp_d_q.size() == 0) check("block_count_de_unexpected", int'(block_count_de_o), 0);
        else check("block_count_d", int'(block_count_d_o), exp_d_q.pop_front());
      end
      if (auto_cmd12_req_o) begin
        if (exp_cmd12_q.size() == 0) check("auto_cmd12_req_unexpected", int'(auto_cmd12_req_o), 0);
        else check("auto_cmd12_req", int'(auto_cmd12_req_o), exp_cmd12_q.pop_front());
      end
      if (data_error_o) begin
        if (exp_err_q.size() == 0) check("data_error_unexpected", int'(data_error_o), 0);
        else check("data_error", int'(data_error_o), exp_err_q.pop_front());
      end
    end
  end

  // Checks the condition now, then at each later negedge, within a cycle budget.
  task automatic wait_for(input int which, input string name);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 300; i++) begin
      case (which)
        W_BWE:   hit = buffer_write_enable_o;
        W_BRE:   hit = buffer_read_enable_o;
        W_START: hit = blk_start_o;
        W_REQ:   hit = auto_cmd12_req_o;
        default: hit = !read_transfer_active_o && !write_transfer_active_o;
      endcase
      if (hit) break;
      @(negedge clk_i);
    end
    check(name, int'(hit), 1);
  endtask

  task automatic pulse(input int which);
    case (which)
      P_START:       start_i = 1'b1;
      P_WR:          buf_block_written_i = 1'b1;
      P_DRAIN:       buf_block_drained_i = 1'b1;
      P_DONE:        blk_done_i = 1'b1;
      P_ERR:         blk_err_i = 1'b1;
      P_ERRDONE:     begin blk_err_i = 1'b1; blk_done_i = 1'b1; end
      P_ABORT:       abort_i = 1'b1;
      P_CMD12:       auto_cmd12_done_i = 1'b1;
      default:       begin buf_block_drained_i = 1'b1; auto_cmd12_done_i = 1'b1; end
    endcase
    @(negedge clk_i);
    start_i = 1'b0; buf_block_written_i = 1'b0; buf_block_drained_i = 1'b0;
    blk_done_i = 1'b0; blk_err_i = 1'b0; abort_i = 1'b0; auto_cmd12_done_i = 1'b0;
  endtask

  task automatic idle();
    repeat ($urandom_range(0, 3)) @(negedge clk_i);
  endtask

  task automatic flush();
    exp_len_q.delete(); exp_d_q.delete(); exp_cmd12_q.delete(); exp_err_q.delete();
  endtask

  task automatic hard_reset();
    rst_ni = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    flush();
    last_len = 0;
    last_d = 0;
  endtask

  // One transfer: model computes the expected pulses, then the driver plays PHY/host.
  task automatic run_xfer(input bit rd, input bit multi, input bit en, input bit acmd,
                          input int cnt, input int size, input int nblk_inf,
                          input int err_blk, input bit poke);
    int  total, starts, done_blks, len, order;
    bit  inf, has_err, cmd12_exp, last;
    inf       = multi && !en;
    total     = !multi ? 1 : (en ? cnt : nblk_inf);
    has_err   = err_blk < total;
    done_blks = has_err ? err_blk : total;
    starts    = has_err ? err_blk + 1 : total;
    len       = (size > MaxBlk) ? MaxBlk : size;
    cmd12_exp = multi && acmd && (has_err || !inf);
    for (int i = 0; i < starts; i++) exp_len_q.push_back(len);
    if (multi && en)
      for (int k = 1; k <= done_blks; k++) begin
        exp_d_q.push_back((cnt - k) & 16'hFFFF);
        last_d = (cnt - k) & 16'hFFFF;
      end
    if (has_err) exp_err_q.push_back(1);
    if (cmd12_exp) exp_cmd12_q.push_back(1);
    last_len = len;

    dir_read_i = rd; multi_block_i = multi; block_count_en_i = en;
    auto_cmd12_en_i = acmd; block_count_i = 16'(cnt); block_size_i = 12'(size);
    pulse(P_START);
    // Scramble the mode inputs: the transfer must run on the latched copies.
    dir_read_i = 1'($urandom); multi_block_i = 1'($urandom);
    block_count_en_i = 1'($urandom); auto_cmd12_en_i = 1'($urandom);
    block_count_i = 16'($urandom); block_size_i = 12'($urandom);

    for (int b = 0; b < starts; b++) begin
      last = (b == starts - 1);
      if (!rd) begin
        wait_for(W_BWE, "wait_buffer_write_enable");
        idle();
        pulse(P_WR);
      end
      wait_for(W_START, "wait_blk_start");
      if (poke && b == 0) begin
        dir_read_i = 1'b0; block_size_i = 12'd300; multi_block_i = 1'b1;
        pulse(P_START);
        check("ignored_start_wr_active", int'(write_transfer_active_o), 0);
        check("ignored_start_rd_active", int'(read_transfer_active_o), 1);
      end else begin
        @(negedge clk_i);
      end
      idle();
      if (has_err && b == err_blk) begin
        pulse((force_errdone || $urandom_range(0, 1) == 1) ? P_ERRDONE : P_ERR);
        break;
      end
      pulse(P_DONE);
      if (rd) begin
        wait_for(W_BRE, "wait_buffer_read_enable");
        if (last && inf) break;
        if (last && cmd12_exp) begin
          wait_for(W_REQ, "wait_cmd12_req_read");
          order = $urandom_range(0, 2);
          idle();
          if (order == 0) begin
            pulse(P_CMD12);
            check("rd_active_until_drain", int'(read_transfer_active_o), 1);
            idle();
            pulse(P_DRAIN);
          end else if (order == 1) begin
            pulse(P_DRAIN);
            check("rd_active_until_cmd12", int'(read_transfer_active_o), 1);
            idle();
            pulse(P_CMD12);
          end else begin
            pulse(P_DRAIN_CMD12);
          end
        end else begin
          idle();
          pulse(P_DRAIN);
        end
      end else if (last && inf) begin
        wait_for(W_BWE, "wait_buffer_write_enable_inf");
      end
    end

    if (inf && !has_err) begin
      idle();
      pulse(P_ABORT);
      check("abort_wr_active", int'(write_transfer_active_o), 0);
      check("abort_rd_active", int'(read_transfer_active_o), 0);
      check("abort_buf_enables", int'(buffer_read_enable_o | buffer_write_enable_o), 0);
    end else if (cmd12_exp && (!rd || has_err)) begin
      wait_for(W_REQ, "wait_cmd12_req");
      idle();
      pulse(P_CMD12);
    end

    wait_for(W_IDLE, "wait_transfer_end");
    @(negedge clk_i);
    check("end_buf_enables", int'(buffer_read_enable_o | buffer_write_enable_o), 0);
    check("end_block_count_d", int'(block_count_d_o), last_d);
    check("missing_blk_start", exp_len_q.size(), 0);
    check("missing_block_count_de", exp_d_q.size(), 0);
    check("missing_cmd12_req", exp_cmd12_q.size(), 0);
    check("missing_data_error", exp_err_q.size(), 0);
    if (read_transfer_active_o || write_transfer_active_o || exp_len_q.size() != 0 ||
        exp_d_q.size() != 0 || exp_cmd12_q.size() != 0 || exp_err_q.size() != 0)
      hard_reset();
  endtask

  // Count enabled with zero blocks: nothing may move for 20 cycles.
  task automatic zero_count_test();
    dir_read_i = 1'($urandom); multi_block_i = 1'b1; block_count_en_i = 1'b1;
    auto_cmd12_en_i = 1'b1; block_count_i = 16'd0; block_size_i = 12'd77;
    pulse(P_START);
    for (int i = 0; i < 20; i++) begin
      check("zero_count_quiet",
            int'({blk_start_o, read_transfer_active_o, write_transfer_active_o,
                  buffer_read_enable_o, buffer_write_enable_o, block_count_de_o,
                  auto_cmd12_req_o, data_error_o}), 0);
      @(negedge clk_i);
    end
    check("zero_count_blk_len", int'(blk_len_o), last_len);
    check("zero_count_count_d", int'(block_count_d_o), last_d);
  endtask

  // Asynchronous reset in the middle of a write must clear outputs at once.
  task automatic mid_reset_test();
    dir_read_i = 1'b0; multi_block_i = 1'b1; block_count_en_i = 1'b1;
    auto_cmd12_en_i = 1'b0; block_count_i = 16'd3; block_size_i = 12'd64;
    exp_len_q.push_back(64);
    pulse(P_START);
    wait_for(W_BWE, "reset_test_bwe");
    pulse(P_WR);
    wait_for(W_START, "reset_test_blk_start");
    #2 rst_ni = 1'b0;
    #1;
    check("async_reset_wr_active", int'(write_transfer_active_o), 0);
    check("async_reset_blk_len", int'(blk_len_o), 0);
    check("async_reset_pulses", int'({blk_start_o, buffer_write_enable_o}), 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    flush();
    last_len = 0;
    last_d = 0;
    @(negedge clk_i);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit rd, multi, en, acmd;
    int cnt, nblk, size, errb;
    repeat (3) @(negedge clk_i);
    check("reset_flags",
          int'({blk_start_o, read_transfer_active_o, write_transfer_active_o,
                buffer_read_enable_o, buffer_write_enable_o, block_count_de_o,
                auto_cmd12_req_o, data_error_o}), 0);
    check("reset_blk_len", int'(blk_len_o), 0);
    check("reset_count_d", int'(block_count_d_o), 0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Directed cases.
    run_xfer(1'b0, 1'b0, 1'b0, 1'b0, 1, 512, 0, NoErr, 1'b0);
    run_xfer(1'b1, 1'b1, 1'b1, 1'b1, 3, 512, 0, NoErr, 1'b0);
    zero_count_test();
    run_xfer(1'b0, 1'b1, 1'b0, 1'b1, 0, 512, 5, NoErr, 1'b0);
    force_errdone = 1'b1;
    run_xfer(1'b1, 1'b1, 1'b1, 1'b1, 4, 256, 0, 1, 1'b0);
    run_xfer(1'b0, 1'b1, 1'b1, 1'b1, 4, 256, 0, 1, 1'b0);
    force_errdone = 1'b0;
    run_xfer(1'b1, 1'b1, 1'b1, 1'b0, 2, 100, 0, NoErr, 1'b1);
    run_xfer(1'b0, 1'b0, 1'b0, 1'b0, 1, 4095, 0, NoErr, 1'b0);
    run_xfer(1'b1, 1'b0, 1'b0, 1'b0, 1, 2049, 0, NoErr, 1'b0);
    run_xfer(1'b1, 1'b0, 1'b0, 1'b0, 1, 2048, 0, NoErr, 1'b0);
    run_xfer(1'b0, 1'b1, 1'b1, 1'b0, 65535, 32, 0, 2, 1'b0);
    mid_reset_test();

    // Randomized transfers.
    for (int t = 0; t < 30; t++) begin
      rd    = 1'($urandom);
      multi = 1'($urandom);
      en    = 1'($urandom);
      acmd  = 1'($urandom);
      cnt   = $urandom_range(1, 4);
      nblk  = $urandom_range(1, 3);
      size  = $urandom_range(0, 4095);
      errb  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : NoErr;
      run_xfer(rd, multi, en, acmd, cnt, size, nblk, errb, 1'b0);
      if (t % 10 == 5) zero_count_test();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
